bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Parametrised multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Accepts a parallel binary word over a valid/ready handshake and returns a packed BCD result plus an overflow flag over a second valid/ready handshake.
- Sits between arithmetic datapaths and the display/formatting blocks.
- Supports abort and output backpressure.

Parameters:
- BIN_W, 8: binary input width in bits; must be ≥1.
- DIGITS, 3: number of BCD digits produced; must be ≥1. Sized by the integrator; undersizing is legal and reported through ovf.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept a new word.
- bin_in  input  BIN_W  unsigned binary value.
- abort  input  1  cancel any conversion in progress.
- out_valid  output  1  bcd_out/ovf are valid.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], with digit 0 = ones.
- ovf  output  1  value exceeded 10^DIGITS−1.
- busy  output  1  conversion in progress.

Behaviour:
- Reset (rst=1 at an edge) takes priority over every other input.
  - State goes to IDLE.
  - bcd_out=0, ovf=0, out_valid=0, busy=0, in_ready=1.
  - Internal shift register, working BCD register and counter are cleared.
  - Applies mid-conversion and mid-output-hold; the pending result is discarded.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - When in_valid=1, latch bin_in into the shift register, clear the working BCD register, counter and sticky overflow, then go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1. in_valid is ignored.
  - Each cycle, in this order:
    - Every working digit ≥5 gets +3 (mod 16).
    - The {working BCD, shift register} concatenation shifts left 1; the MSB of the shift register enters digit 0's LSB.
    - The bit leaving digit DIGITS−1's MSB is ORed into the sticky overflow.
    - The counter increments.
  - After the BIN_W-th shift, go to DONE. On that same edge, load bcd_out from the working register and ovf from the sticky overflow.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - bcd_out and ovf hold stable while out_valid=1 and out_ready=0.
  - When out_ready=1, go to IDLE. out_valid drops on the next cycle.
  - A new word is not accepted in the same cycle as the output handshake.
- Between conversions, bcd_out/ovf keep their last values. Consumers qualify them with out_valid only.
- Latency and throughput:
  - out_valid rises exactly BIN_W edges after the accepting edge.
  - Minimum period between accepts is BIN_W+2 cycles.
- Overflow semantics: bcd_out = value mod 10^DIGITS; ovf=1 iff value ≥ 10^DIGITS.
- abort (sampled when rst=0):
  - In SHIFT or DONE: go to IDLE next edge. No out_valid is produced; bcd_out/ovf are unchanged.
  - Takes priority over the completion edge and over the output handshake.
  - In IDLE: blocks acceptance that cycle.
- Width rules:
  - Counter width is clog2(BIN_W+1).
  - BIN_W=1 and DIGITS=1 are legal: single-shift conversion; single digit with overflow at ≥10.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
- BIN_W=8, DIGITS=3, bin_in=255 accepted at edge E0 → out_valid high after edge E8; bcd_out=12'h255, ovf=0. Repeat with 0 → 12'h000; with 99 → 12'h099; with 100 → 12'h100.
- BIN_W=8, DIGITS=2, bin_in=200 → bcd_out=8'h00, ovf=1. Then bin_in=199 → 8'h99, ovf=1. Then bin_in=99 → 8'h99, ovf=0.
- Backpressure: result 12'h128 with out_ready=0 for 5 cycles → out_valid and bcd_out stable all 5 cycles. Raise out_ready → IDLE next cycle. in_valid pulses during SHIFT/DONE are ignored and in_ready stays 0.
- Abort at shift 4 of bin_in=173 → no out_valid, bcd_out keeps its prior value, in_ready=1 next cycle. Then accept 42 → 12'h042 after 8 edges.
- Synchronous reset mid-SHIFT, and separately in DONE → all outputs at reset values after the edge; rst asserted between edges with no clock edge has no effect. Next conversion of 255 → correct result.
- BIN_W=16, DIGITS=5: random sweep of 1000 values plus 65535 → bcd_out matches a decimal reference model, ovf=0, latency=16. Back-to-back accepts are spaced exactly 18 cycles with out_ready held at 1.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle binary-to-BCD converter, one double-dabble
// step per clock, valid/ready handshake on input and output.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, bin_in carries the binary word
//   abort                cancel a conversion or a pending result
//   out_valid/out_ready  output handshake, bcd_out/ovf carry the result
//   busy                 high while shifting
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_sr;
  logic [BCD_W-1:0]   r_work;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_out_valid;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_next_work;
  logic               w_carry;

  // Add-3 correction on every digit that will reach 10+ after doubling.
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_work[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit shifted out of the top digit means the value has passed
  // 10^DIGITS; the remaining digits still track value mod 10^DIGITS.
  assign w_next_work = {w_adj[BCD_W-2:0], r_sr[BIN_W-1]};
  assign w_carry     = w_adj[BCD_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_work      <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_sticky    <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !abort) begin
            r_sr       <= bin_in;
            r_work     <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
            r_state    <= S_SHIFT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_work   <= w_next_work;
            r_sr     <= r_sr << 1;
            r_sticky <= r_sticky | w_carry;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
              r_bcd       <= w_next_work;
              r_ovf       <= r_sticky | w_carry;
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Result stays put under backpressure; abort just drops it.
          if (abort || out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq with three instances
// (8b/3 digits, 8b/2 digits sharing inputs, and 16b/5 digits).
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, abort, out_ready;
  logic [7:0]  bin;
  logic        a_in_ready, a_out_valid, a_busy, a_ovf;
  logic [11:0] a_bcd;
  logic        b_in_ready, b_out_valid, b_busy, b_ovf;
  logic [7:0]  b_bcd;

  logic        c_rst, c_in_valid, c_abort, c_out_ready;
  logic [15:0] c_bin;
  logic        c_in_ready, c_out_valid, c_busy, c_ovf;
  logic [19:0] c_bcd;

  int checks = 0;
  int failures = 0;
  int cur;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .bin_in(bin), .abort(abort), .out_valid(a_out_valid),
    .out_ready(out_ready), .bcd_out(a_bcd), .ovf(a_ovf), .busy(a_busy)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .bin_in(bin), .abort(abort), .out_valid(b_out_valid),
    .out_ready(out_ready), .bcd_out(b_bcd), .ovf(b_ovf), .busy(b_busy)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .bin_in(c_bin), .abort(c_abort), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .bcd_out(c_bcd), .ovf(c_ovf), .busy(c_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref5(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One full conversion on instances a and b with exact latency check.
  task automatic conv(input logic [7:0] v, input logic [11:0] ea,
                      input logic [7:0] eb, input logic eob);
    in_valid = 1'b1;
    bin = v;
    tick;
    in_valid = 1'b0;
    chk("acc_busy", 32'(a_busy), 32'd1);
    chk("acc_in_ready", 32'(a_in_ready), 32'd0);
    repeat (7) tick;
    chk("lat_early", 32'(a_out_valid), 32'd0);
    tick;
    chk("a_out_valid", 32'(a_out_valid), 32'd1);
    chk("a_bcd", 32'(a_bcd), 32'(ea));
    chk("a_ovf", 32'(a_ovf), 32'd0);
    chk("b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_bcd", 32'(b_bcd), 32'(eb));
    chk("b_ovf", 32'(b_ovf), 32'(eob));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(a_out_valid), 32'd0);
    chk("hs_in_ready", 32'(a_in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    bin = '0;
    c_rst = 1'b1;
    c_in_valid = 1'b0;
    c_abort = 1'b0;
    c_out_ready = 1'b0;
    c_bin = '0;
    tick;
    tick;
    rst = 1'b0;
    c_rst = 1'b0;

    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_bcd", 32'(a_bcd), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_b_ovf", 32'(b_ovf), 32'd0);
    chk("rst_c_in_ready", 32'(c_in_ready), 32'd1);

    conv(8'd255, 12'h255, 8'h55, 1'b1);
    conv(8'd0,   12'h000, 8'h00, 1'b0);
    conv(8'd99,  12'h099, 8'h99, 1'b0);
    conv(8'd100, 12'h100, 8'h00, 1'b1);
    conv(8'd200, 12'h200, 8'h00, 1'b1);
    conv(8'd199, 12'h199, 8'h99, 1'b1);
    conv(8'd99,  12'h099, 8'h99, 1'b0);

    // Backpressure, with in_valid noise during SHIFT and DONE.
    in_valid = 1'b1;
    bin = 8'd128;
    tick;
    for (int i = 0; i < 7; i++) begin
      in_valid = i[0];
      bin = 8'd7;
      tick;
      chk("bp_shift_in_ready", 32'(a_in_ready), 32'd0);
    end
    in_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(a_out_valid), 32'd1);
      chk("bp_bcd", 32'(a_bcd), 32'h128);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      in_valid = 1'b1;
      tick;
    end
    chk("bp_hold_end", 32'(a_out_valid), 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_rel_out_valid", 32'(a_out_valid), 32'd0);
    chk("bp_rel_busy", 32'(a_busy), 32'd0);
    chk("bp_rel_in_ready", 32'(a_in_ready), 32'd1);
    tick;
    chk("bp_idle_busy", 32'(a_busy), 32'd0);

    // Abort at the 4th shift.
    in_valid = 1'b1;
    bin = 8'd173;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_in_ready", 32'(a_in_ready), 32'd1);
    chk("ab_busy", 32'(a_busy), 32'd0);
    chk("ab_out_valid", 32'(a_out_valid), 32'd0);
    chk("ab_bcd_kept", 32'(a_bcd), 32'h128);
    repeat (8) tick;
    chk("ab_no_result", 32'(a_out_valid), 32'd0);
    chk("ab_bcd_late", 32'(a_bcd), 32'h128);
    conv(8'd42, 12'h042, 8'h42, 1'b0);

    // Abort in IDLE blocks acceptance.
    abort = 1'b1;
    in_valid = 1'b1;
    bin = 8'd5;
    tick;
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abidle_in_ready", 32'(a_in_ready), 32'd1);
    chk("abidle_busy", 32'(a_busy), 32'd0);

    // Abort in DONE wins over the handshake.
    in_valid = 1'b1;
    bin = 8'd9;
    tick;
    in_valid = 1'b0;
    repeat (8) tick;
    chk("abdone_valid", 32'(a_out_valid), 32'd1);
    chk("abdone_bcd", 32'(a_bcd), 32'h009);
    abort = 1'b1;
    out_ready = 1'b1;
    tick;
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abdone_out_valid", 32'(a_out_valid), 32'd0);
    chk("abdone_in_ready", 32'(a_in_ready), 32'd1);
    chk("abdone_bcd_kept", 32'(a_bcd), 32'h009);

    // Abort on the completion edge.
    in_valid = 1'b1;
    bin = 8'd77;
    tick;
    in_valid = 1'b0;
    repeat (7) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abcomp_out_valid", 32'(a_out_valid), 32'd0);
    chk("abcomp_in_ready", 32'(a_in_ready), 32'd1);
    chk("abcomp_bcd", 32'(a_bcd), 32'h009);

    // Reset mid-SHIFT.
    in_valid = 1'b1;
    bin = 8'd255;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rsh_bcd", 32'(a_bcd), 32'd0);
    chk("rsh_b_bcd", 32'(b_bcd), 32'd0);
    chk("rsh_busy", 32'(a_busy), 32'd0);
    chk("rsh_in_ready", 32'(a_in_ready), 32'd1);
    chk("rsh_out_valid", 32'(a_out_valid), 32'd0);

    // Reset in DONE, preceded by a pulse that sees no edge.
    in_valid = 1'b1;
    bin = 8'd255;
    tick;
    in_valid = 1'b0;
    repeat (8) tick;
    chk("rdn_pre_valid", 32'(a_out_valid), 32'd1);
    chk("rdn_pre_b_ovf", 32'(b_ovf), 32'd1);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    chk("glitch_out_valid", 32'(a_out_valid), 32'd1);
    chk("glitch_bcd", 32'(a_bcd), 32'h255);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rdn_out_valid", 32'(a_out_valid), 32'd0);
    chk("rdn_bcd", 32'(a_bcd), 32'd0);
    chk("rdn_b_ovf", 32'(b_ovf), 32'd0);
    chk("rdn_in_ready", 32'(a_in_ready), 32'd1);
    conv(8'd255, 12'h255, 8'h55, 1'b1);

    // 16-bit sweep, back-to-back with in_valid and out_ready held high.
    c_out_ready = 1'b1;
    c_in_valid = 1'b1;
    cur = int'($urandom_range(0, 65535));
    c_bin = 16'(cur);
    for (int i = 0; i < 1001; i++) begin
      tick;
      chk("c_acc_busy", 32'(c_busy), 32'd1);
      repeat (15) tick;
      chk("c_lat_early", 32'(c_out_valid), 32'd0);
      tick;
      chk("c_out_valid", 32'(c_out_valid), 32'd1);
      chk("c_bcd", 32'(c_bcd), 32'(ref5(cur)));
      chk("c_ovf", 32'(c_ovf), 32'd0);
      if (i == 999) cur = 65535;
      else cur = int'($urandom_range(0, 65535));
      c_bin = 16'(cur);
      if (i == 1000) c_in_valid = 1'b0;
      tick;
      chk("c_hs_in_ready", 32'(c_in_ready), 32'd1);
      chk("c_hs_out_valid", 32'(c_out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
